mbox_ebox_resp: RTL

MBOX-side responder for the EBOX memory-request interface. Accepts EBOX read, write and read-pause-write requests, and signals acceptance with `cshEBOXT0` or rejection with `cshEBOXRetry`. Runs each accepted request against a simple backing-memory port, then returns completion on `mboxRespIn` with read data on `cacheDataRead`. It stands in for the cache/MBOX pipeline behind the EBOX and also serves as its bench model.

---
 rtl/mbox_ebox_resp.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mbox_ebox_resp.sv
// mbox_ebox_resp: MBOX-side responder for the EBOX memory-request interface.
//
// Accepts EBOX read / write / read-pause-write (PSE) requests, answers with
// an accept pulse (cshEBOXT0) or a reject pulse (cshEBOXRetry), runs the
// accepted request against a simple backing-memory port and signals
// completion on mboxRespIn with read data held on cacheDataRead.
//
// Optional feature macro: MBOX_PARITY_EN
//   defined   : odd parity generated on memWPar, read parity checked into
//               the sticky mbParErr flag.
//   undefined : memWPar = 0, mbParErr = 0, memRPar ignored.
//
// Handshakes:
//   EBOX side  - eboxReq is only looked at in IDLE and PSEWAIT. Each sampled
//                request is answered by exactly one single-cycle pulse, either
//                cshEBOXRetry (EBOX must re-request) or cshEBOXT0 followed
//                later by one mboxRespIn pulse. A new request can be taken in
//                the cycle after mboxRespIn.
//   Memory side - memReq is held high with memAddr/memWrite/memWData stable
//                until memAck is sampled high or the NXM timeout fires; a
//                memAck seen while memReq is low is ignored.
//
// Bit numbering follows the EBOX convention: bit 0 / bit 13 is the MSB.

module mbox_ebox_resp #(
  parameter int unsigned NXM_TIMEOUT = 64
) (
  input  logic         mboxClk,
  input  logic         mboxResetN,
  // EBOX request side
  input  logic         eboxReq,
  input  logic [13:35] EBOX_VMA,
  input  logic         eboxRead,
  input  logic         eboxWrite,
  input  logic         eboxPSE,
  input  logic [0:35]  cacheDataWrite,
  output logic         cshEBOXT0,
  output logic         cshEBOXRetry,
  output logic         mboxRespIn,
  output logic [0:35]  cacheDataRead,
  // error flags
  output logic         nxmErr,
  output logic         mbParErr,
  input  logic         errClr,
  // backing-memory port
  input  logic         memBusy,
  output logic         memReq,
  output logic         memWrite,
  output logic         memLock,
  output logic [13:35] memAddr,
  output logic [0:35]  memWData,
  output logic         memWPar,
  input  logic         memAck,
  input  logic [0:35]  memRData,
  input  logic         memRPar,
  // debug: current FSM state
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RETRY   = 3'd1,
    S_T0      = 3'd2,
    S_MEM     = 3'd3,
    S_RESP    = 3'd4,
    S_PSEWAIT = 3'd5
  } state_t;

  // Last counter value of the MEM wait window; memReq is high for exactly
  // NXM_TIMEOUT cycles before an abort.
  localparam logic [9:0] TMO_LAST = 10'(NXM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [13:35]  addr_q, addr_d;
  logic [0:35]   wdata_q, wdata_d;
  logic [0:35]   rdata_q, rdata_d;
  logic          wr_q, wr_d;       // latched request is a write
  logic          rd_q, rd_d;       // latched request is a read
  logic          pse_q, pse_d;     // latched request is a PSE read
  logic          lock_q, lock_d;   // memory lock for a PSE sequence
  logic          abort_q, abort_d; // current request ended in NXM abort
  logic [9:0]    cnt_q, cnt_d;     // MEM wait counter
  logic          nxm_q, nxm_d;
  logic          nxm_set;
  logic          par_set;
  logic          take_fresh;       // treat eboxReq as a new request this cycle
  logic          lock_seen;        // lock state the busy check sees

  // Next-state, datapath latch and error-set decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    pse_d      = pse_q;
    lock_d     = lock_q;
    abort_d    = abort_q;
    cnt_d      = cnt_q;
    nxm_set    = 1'b0;
    par_set    = 1'b0;
    take_fresh = 1'b0;
    lock_seen  = lock_q;

    case (state_q)
      S_IDLE: begin
        take_fresh = eboxReq;
      end

      S_RETRY: begin
        // eboxReq is deliberately not looked at here
        state_d = S_IDLE;
      end

      S_T0: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        // a request with neither flag set completes without a memory cycle
        if (wr_q || rd_q) begin
          state_d = S_MEM;
        end else begin
          state_d = S_RESP;
        end
      end

      S_MEM: begin
        if (memAck) begin
          if (rd_q) begin
            rdata_d = memRData;
`ifdef MBOX_PARITY_EN
            // odd parity expected over data+parity; an even total is an error
            if ((^{memRData, memRPar}) == 1'b0) begin
              par_set = 1'b1;
            end
`endif
          end
          state_d = S_RESP;
        end else if (cnt_q == TMO_LAST) begin
          nxm_set = 1'b1;
          abort_d = 1'b1;
          if (rd_q) begin
            rdata_d = '0;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end

      S_RESP: begin
        // a successful PSE read keeps the lock and waits for its write;
        // everything else (including the PSE write itself) releases it
        if (pse_q && !abort_q) begin
          state_d = S_PSEWAIT;
        end else begin
          state_d = S_IDLE;
          lock_d  = 1'b0;
        end
      end

      S_PSEWAIT: begin
        if (eboxReq) begin
          if (eboxWrite) begin
            // write-back of the PSE: address stays the latched PSE address
            state_d = S_T0;
            wr_d    = 1'b1;
            rd_d    = 1'b0;
            pse_d   = 1'b0;
            wdata_d = cacheDataWrite;
          end else begin
            // PSE abandoned: release the lock and treat as a fresh request
            lock_d     = 1'b0;
            lock_seen  = 1'b0;
            take_fresh = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (take_fresh) begin
      if (memBusy && !lock_seen) begin
        state_d = S_RETRY;
      end else begin
        state_d = S_T0;
        addr_d  = EBOX_VMA;
        wdata_d = cacheDataWrite;
        wr_d    = eboxWrite;
        rd_d    = !eboxWrite && eboxRead;
        pse_d   = !eboxWrite && eboxRead && eboxPSE;
        lock_d  = !eboxWrite && eboxRead && eboxPSE;
      end
    end

    // set beats clear when both happen in the same cycle
    if (nxm_set) begin
      nxm_d = 1'b1;
    end else if (errClr) begin
      nxm_d = 1'b0;
    end else begin
      nxm_d = nxm_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge mboxClk or negedge mboxResetN) begin
    if (!mboxResetN) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      pse_q   <= 1'b0;
      lock_q  <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
      nxm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      pse_q   <= pse_d;
      lock_q  <= lock_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
      nxm_q   <= nxm_d;
    end
  end

`ifdef MBOX_PARITY_EN
  logic par_q;

  // Sticky read-parity error flag; set beats clear
  always_ff @(posedge mboxClk or negedge mboxResetN) begin
    if (!mboxResetN) begin
      par_q <= 1'b0;
    end else if (par_set) begin
      par_q <= 1'b1;
    end else if (errClr) begin
      par_q <= 1'b0;
    end
  end

  assign mbParErr = par_q;
  assign memWPar  = ~(^wdata_q);
`else
  logic unused_par;

  assign unused_par = memRPar ^ par_set;
  assign mbParErr   = 1'b0;
  assign memWPar    = 1'b0;
`endif

  // Pulses and memory strobes decode straight from state so that an
  // asynchronous reset removes them without waiting for a clock edge.
  assign cshEBOXT0     = (state_q == S_T0);
  assign cshEBOXRetry  = (state_q == S_RETRY);
  assign mboxRespIn    = (state_q == S_RESP);
  assign memReq        = (state_q == S_MEM);
  assign memWrite      = wr_q;
  assign memLock       = lock_q;
  assign memAddr       = addr_q;
  assign memWData      = wdata_q;
  assign cacheDataRead = rdata_q;
  assign nxmErr        = nxm_q;
  assign dbg_state_o   = state_q;

endmodule
